nco_tick_ctrl: RTL and testbench
================================

NCO_TICK_CTRL -- requirements
Module: nco_tick_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_INC, default 32'd6597070: active phase increment after reset (9600 bps x16 at 100 MHz).
REQ-002 SHALL have clk, input, 1: clock; all logic on rising edge.
REQ-003 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have run_req, input, 1: start request, level-sampled.
REQ-005 SHALL have stop_req, input, 1: stop request, level-sampled.
REQ-006 SHALL have inc_in, input, 32: new phase increment (fo x 42.94967296).
REQ-007 SHALL have inc_valid, input, 1 and inc_ready, output, 1: increment handshake; transfer occurs when both are high on a rising edge.
REQ-008 SHALL have burst_len, input, 16: tick count per run; 0 means continuous.
REQ-009 SHALL have tick, output, 1: one-cycle clock-enable pulse per accumulator wrap.
REQ-010 SHALL have clk_out, output, 1: divided clock, registered accumulator bit 31.
REQ-011 SHALL have busy, output, 1 and done, output, 1: busy is high in RUN/STOPPING; done is a one-cycle pulse at burst completion.
REQ-012 SHALL have tick_cnt, output, 16: ticks issued in the current run.

Function
REQ-013 SHALL implement FSM IDLE, RUN, STOPPING; busy = (state != IDLE).
REQ-014 IDLE: accumulator held at 0; tick, clk_out = 0; run_req=1 and stop_req=0 -> RUN, latch burst_len, clear tick_cnt.
REQ-015 run_req and stop_req both high in IDLE: stop wins; stay IDLE.
REQ-016 RUN/STOPPING: acc <= acc + inc_active (32-bit, modulo 2^32) every cycle.
REQ-017 tick SHALL be the registered carry-out of that add: high exactly one cycle, the cycle after the wrapping add.
REQ-018 tick_cnt SHALL increment on each tick and wrap 0xFFFF -> 0 in continuous mode.
REQ-019 burst_len != 0: on the tick making tick_cnt == burst_len, assert done the same cycle as that tick; state -> IDLE next edge.
REQ-020 stop_req in RUN -> STOPPING; the current period completes; on the next tick, -> IDLE; done not asserted.
REQ-021 run_req in RUN/STOPPING and stop_req in STOPPING SHALL be ignored.
REQ-022 inc_ready = 1 when no increment is pending; an accepted nonzero inc_in sets pending; accepted zero is discarded (no pending).
REQ-023 In IDLE, a pending increment SHALL become inc_active on the next edge.
REQ-024 In RUN/STOPPING, a pending increment SHALL be applied only on the edge where the carry occurs, so the new period starts exactly at a tick boundary; inc_ready returns high the next cycle.
REQ-025 Burst completion and stop on the same tick: treated as burst completion (done=1).

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, acc=0, tick=0, clk_out=0, done=0, tick_cnt=0, pending cleared, inc_active=DEFAULT_INC, inc_ready=1.
REQ-027 Reset mid-run SHALL abort without a done pulse; operation resumes only on a new run_req after release.

Configuration
REQ-028 Macro NCO_CLKOUT_EN defined: clk_out register present and driven per REQ-010.
REQ-029 NCO_CLKOUT_EN undefined: clk_out register removed, port tied to 0; tick behaviour unchanged.

Verification
REQ-030 inc=0x4000_0000, burst_len=0, run_req pulse -> tick every 4 cycles; clk_out 50% duty, period 4 (macro defined).
REQ-031 inc=0x4000_0000, burst_len=3 -> exactly 3 ticks; done coincident with third tick; busy low next cycle; tick_cnt=3.
REQ-032 RUN at inc=0x4000_0000, handshake 0x8000_0000 mid-period -> inc_ready low until next tick; period 4 until that tick, then 2.
REQ-033 stop_req one cycle after a tick (inc=0x4000_0000) -> one more tick 3 cycles later, then IDLE; done stays 0.
REQ-034 rst_n low mid-burst -> all outputs at reset values immediately; no done; inc_active back to DEFAULT_INC.
REQ-035 run_req and stop_req together in IDLE -> busy stays 0; no tick.

Source files
------------

// File: rtl/nco_tick_ctrl.sv
// -----------------------------------------------------------------------------
// nco_tick_ctrl
//
// Purpose:
//   A numerically controlled oscillator. Each time the 32-bit phase
//   accumulator wraps, the block emits one clock-enable tick. A run can be
//   continuous or can stop after a fixed number of ticks (a burst). The phase
//   increment can be changed at run time through a valid/ready handshake. The
//   new increment takes effect only at a tick boundary, so no period is
//   ever cut short or stretched.
//
// Configuration:
//   NCO_CLKOUT_EN - when defined, clk_out is a registered copy of accumulator
//                   bit 31. When undefined, that register is not built and
//                   clk_out is tied low. Tick behaviour is identical in both
//                   builds.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   run_req    in   start request (level); accepted in IDLE only
//   stop_req   in   stop request (level); wins over run_req in IDLE
//   inc_in     in   [31:0] new phase increment (fo x 2^32 / fclk)
//   inc_valid  in   increment offered
//   inc_ready  out  no increment pending; transfer when valid && ready
//   burst_len  in   [15:0] ticks per run, 0 = continuous
//   tick       out  one-cycle pulse per accumulator wrap
//   clk_out    out  divided clock (accumulator MSB), or 0 without the macro
//   busy       out  high in RUN and STOPPING
//   done       out  one-cycle pulse together with the final burst tick
//   tick_cnt   out  [15:0] ticks issued in the current run
// -----------------------------------------------------------------------------
module nco_tick_ctrl #(
    parameter logic [31:0] DEFAULT_INC = 32'd6597070
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic        stop_req,
    input  logic [31:0] inc_in,
    input  logic        inc_valid,
    output logic        inc_ready,
    input  logic [15:0] burst_len,
    output logic        tick,
    output logic        clk_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] inc_active_q, inc_active_d;
    logic [31:0] inc_pend_q, inc_pend_d;
    logic        pend_q, pend_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] burst_q, burst_d;

    logic [32:0] sum;
    logic        inc_fire;
    logic        burst_hit;
    logic        finish;

    // Bit 32 of the sum is the wrap (carry-out) that produces a tick.
    assign sum       = {1'b0, acc_q} + {1'b0, inc_active_q};
    assign inc_fire  = inc_valid && !pend_q;
    // The carry about to be registered would be the last tick of the burst.
    assign burst_hit = (burst_q != 16'd0) && ((tick_cnt_q + 16'd1) == burst_q);
    // A run ends on the cycle after its final tick. That final tick is either
    // the burst-completing one (done_q is high with it) or the first tick seen
    // while stopping. No further carry may be issued in that cycle, even when
    // the increment is large enough to wrap every cycle.
    assign finish    = tick_q && (done_q || (state_q == S_STOPPING));

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        inc_active_d = inc_active_q;
        inc_pend_d   = inc_pend_q;
        pend_d       = pend_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        tick_cnt_d   = tick_cnt_q;
        burst_d      = burst_q;

        case (state_q)
            S_IDLE: begin
                acc_d = 32'd0;
                if (pend_q) begin
                    inc_active_d = inc_pend_q;
                    pend_d       = 1'b0;
                end
                if (run_req && !stop_req) begin
                    state_d    = S_RUN;
                    burst_d    = burst_len;
                    tick_cnt_d = 16'd0;
                end
            end

            S_RUN, S_STOPPING: begin
                if (finish) begin
                    state_d = S_IDLE;
                    acc_d   = 32'd0;
                end else begin
                    acc_d = sum[31:0];
                    if (sum[32]) begin
                        tick_d     = 1'b1;
                        tick_cnt_d = tick_cnt_q + 16'd1;
                        done_d     = burst_hit;
                        // Swap the increment exactly at the wrap so the next
                        // period is the first one at the new rate.
                        if (pend_q) begin
                            inc_active_d = inc_pend_q;
                            pend_d       = 1'b0;
                        end
                    end
                    if ((state_q == S_RUN) && stop_req) begin
                        state_d = S_STOPPING;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                acc_d   = 32'd0;
            end
        endcase

        // pend_q is low whenever a transfer fires, so this never collides with
        // the pending-clear paths above. A zero increment is dropped.
        if (inc_fire && (inc_in != 32'd0)) begin
            pend_d     = 1'b1;
            inc_pend_d = inc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= 32'd0;
            inc_active_q <= DEFAULT_INC;
            inc_pend_q   <= 32'd0;
            pend_q       <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_cnt_q   <= 16'd0;
            burst_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            inc_active_q <= inc_active_d;
            inc_pend_q   <= inc_pend_d;
            pend_q       <= pend_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
            tick_cnt_q   <= tick_cnt_d;
            burst_q      <= burst_d;
        end
    end

`ifdef NCO_CLKOUT_EN
    logic clk_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_q <= 1'b0;
        end else begin
            clk_out_q <= acc_d[31];
        end
    end

    assign clk_out = clk_out_q;
`else
    assign clk_out = 1'b0;
`endif

    assign inc_ready = !pend_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_nco_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_tick_ctrl
//
// Directed bench for nco_tick_ctrl. The inputs are driven and the outputs are
// sampled on the falling edge. Cycle index n counts falling edges after the
// one on which run_req is raised. An increment of 0x4000_0000 therefore gives
// ticks at n = 5, 9, 13, ...
// -----------------------------------------------------------------------------
module tb_nco_tick_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run_req;
    logic        stop_req;
    logic [31:0] inc_in;
    logic        inc_valid;
    logic        inc_ready;
    logic [15:0] burst_len;
    logic        tick;
    logic        clk_out;
    logic        busy;
    logic        done;
    logic [15:0] tick_cnt;

    int n_vec;
    int n_miscmp;

    nco_tick_ctrl #(
        .DEFAULT_INC(32'd6597070)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_req   (run_req),
        .stop_req  (stop_req),
        .inc_in    (inc_in),
        .inc_valid (inc_valid),
        .inc_ready (inc_ready),
        .burst_len (burst_len),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy),
        .done      (done),
        .tick_cnt  (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Loads an increment while IDLE. The increment is pending for one cycle
    // and then becomes active.
    task automatic set_inc(input logic [31:0] v);
        chk("set_inc_ready_before", {31'd0, inc_ready}, 32'd1);
        inc_in    = v;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
        chk("set_inc_ready_pending", {31'd0, inc_ready}, 32'd0);
        step();
        chk("set_inc_ready_applied", {31'd0, inc_ready}, 32'd1);
        $display("set increment %08h", v);
    endtask

    logic [15:0] exp_tick;
    logic [15:0] exp_clk;
    logic [15:0] exp_done;
    logic        seen_done;
    int          n_hit;

    initial begin
        n_vec     = 0;
        n_miscmp  = 0;
        rst_n     = 1'b0;
        run_req   = 1'b0;
        stop_req  = 1'b0;
        inc_in    = 32'd0;
        inc_valid = 1'b0;
        burst_len = 16'd0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_tick",     {31'd0, tick},      32'd0);
        chk("rst_clk_out",  {31'd0, clk_out},   32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_tick_cnt", {16'd0, tick_cnt},  32'd0);
        chk("rst_inc_rdy",  {31'd0, inc_ready}, 32'd1);
        rst_n = 1'b1;
        step();
        $display("reset released");

        // ---------------- A: continuous, clk_out, stop after tick ----------------
        set_inc(32'h4000_0000);
        exp_tick = 16'h2220;
`ifdef NCO_CLKOUT_EN
        exp_clk = 16'h1998;
`else
        exp_clk = 16'h0000;
`endif
        burst_len = 16'd0;
        run_req   = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (n == 1) run_req = 1'b0;
            chk($sformatf("A_tick_n%0d", n), {31'd0, tick},    {31'd0, exp_tick[n]});
            chk($sformatf("A_clk_n%0d", n),  {31'd0, clk_out}, {31'd0, exp_clk[n]});
            chk($sformatf("A_busy_n%0d", n), {31'd0, busy},    (n <= 13) ? 32'd1 : 32'd0);
            chk($sformatf("A_done_n%0d", n), {31'd0, done},    32'd0);
            if (n == 9)  chk("A_cnt_n9",  {16'd0, tick_cnt}, 32'd2);
            if (n == 13) chk("A_cnt_n13", {16'd0, tick_cnt}, 32'd3);
            if (n == 10) stop_req = 1'b1;
            if (n == 11) stop_req = 1'b0;
        end
        $display("A continuous run with stop done");

        // ---------------- B: burst of 3 ----------------
        exp_done  = 16'h2000;
        burst_len = 16'd3;
        run_req   = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            if (n == 1) run_req = 1'b0;
            chk($sformatf("B_tick_n%0d", n), {31'd0, tick}, {31'd0, exp_tick[n]});
            chk($sformatf("B_done_n%0d", n), {31'd0, done}, {31'd0, exp_done[n]});
            chk($sformatf("B_busy_n%0d", n), {31'd0, busy}, (n <= 13) ? 32'd1 : 32'd0);
            if (n == 5)  chk("B_cnt_n5",  {16'd0, tick_cnt}, 32'd1);
            if (n == 13) chk("B_cnt_n13", {16'd0, tick_cnt}, 32'd3);
            if (n == 15) chk("B_cnt_n15", {16'd0, tick_cnt}, 32'd3);
        end
        $display("B burst of 3 done");

        // ---------------- C: increment change mid-period ----------------
        exp_tick  = 16'hAA20;
        burst_len = 16'd0;
        run_req   = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n == 1) run_req = 1'b0;
            if (n == 7) inc_valid = 1'b0;
            chk($sformatf("C_tick_n%0d", n), {31'd0, tick}, {31'd0, exp_tick[n]});
            chk($sformatf("C_busy_n%0d", n), {31'd0, busy}, (n <= 15) ? 32'd1 : 32'd0);
            if (n == 7 || n == 8) chk($sformatf("C_rdy_n%0d", n), {31'd0, inc_ready}, 32'd0);
            if (n == 9)  chk("C_rdy_n9", {31'd0, inc_ready}, 32'd1);
            if (n == 6) begin
                inc_in    = 32'h8000_0000;
                inc_valid = 1'b1;
            end
            if (n == 13) stop_req = 1'b1;
            if (n == 14) stop_req = 1'b0;
        end
        $display("C increment handshake mid-run done");

        // ---------------- D: reset mid-burst ----------------
        burst_len = 16'd5;
        run_req   = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) run_req = 1'b0;
            if (n == 5) inc_valid = 1'b0;
            if (n == 3) chk("D_tick_n3", {31'd0, tick}, 32'd1);
            if (n == 4) begin
                inc_in    = 32'h1000_0000;
                inc_valid = 1'b1;
            end
        end
        chk("D_pre_tick",  {31'd0, tick},      32'd1);
        chk("D_pre_rdy",   {31'd0, inc_ready}, 32'd0);
        chk("D_pre_cnt",   {16'd0, tick_cnt},  32'd2);
        rst_n = 1'b0;
        #1;
        chk("D_rst_tick",    {31'd0, tick},      32'd0);
        chk("D_rst_busy",    {31'd0, busy},      32'd0);
        chk("D_rst_done",    {31'd0, done},      32'd0);
        chk("D_rst_cnt",     {16'd0, tick_cnt},  32'd0);
        chk("D_rst_rdy",     {31'd0, inc_ready}, 32'd1);
        chk("D_rst_clk_out", {31'd0, clk_out},   32'd0);
        step();
        chk("D_rst_done_hold", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("D_idle_busy_n%0d", n), {31'd0, busy}, 32'd0);
            chk($sformatf("D_idle_done_n%0d", n), {31'd0, done}, 32'd0);
        end
        // Default increment 6597070: 651 adds stay below 2^32, the 652nd wraps.
        burst_len = 16'd0;
        run_req   = 1'b1;
        seen_done = 1'b0;
        n_hit     = 801;
        for (int n = 1; n <= 800; n++) begin
            step();
            if (n == 1) run_req = 1'b0;
            if (done) seen_done = 1'b1;
            if (tick) begin
                n_hit = n;
                break;
            end
        end
        chk("D_default_inc_first_tick", n_hit, 32'd653);
        chk("D_no_done", {31'd0, seen_done}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        $display("D reset mid-burst done");

        // ---------------- E: run+stop together, zero increment ----------------
        run_req  = 1'b1;
        stop_req = 1'b1;
        step();
        run_req  = 1'b0;
        stop_req = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("E_busy_n%0d", n), {31'd0, busy}, 32'd0);
            chk($sformatf("E_tick_n%0d", n), {31'd0, tick}, 32'd0);
            step();
        end
        inc_in    = 32'd0;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
        chk("E_zero_inc_rdy", {31'd0, inc_ready}, 32'd1);
        $display("E run/stop conflict and zero increment done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
